p2s_serializer: RTL and testbench

//  Parametrised parallel-to-serial converter; next generation of the 4-bit p2s.

---
 rtl/p2s_serializer.sv | 95 +++++++++
 tb/tb_p2s_serializer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/p2s_serializer.sv
// p2s_serializer: parametrised parallel-to-serial converter.
// Accepts a WIDTH-bit word over din_vld/din_rdy and shifts it out one bit per
// ser_en cycle, with sof/eof frame markers and gapless back-to-back frames.
// Optional feature macro: P2S_PARITY_EN appends an even-parity bit (^din)
// after the data bits. With it, the frame is WIDTH+1 bits long.
module p2s_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic             din_rdy,
  input  logic             ser_en,
  output logic             dout,
  output logic             dout_vld,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

`ifdef P2S_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_q, state_d;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [FRAME_LEN-1:0] load_word;
  logic [FRAME_LEN-1:0] shifted;
  logic                 out_bit;
  logic                 load;

  // The shift register holds the whole frame. The parity bit sits at the far
  // end from the output so that it leaves after every data bit.
`ifdef P2S_PARITY_EN
  assign load_word = MSB_FIRST ? {din, ^din} : {^din, din};
`else
  assign load_word = din;
`endif

  assign shifted = MSB_FIRST ? {shreg_q[FRAME_LEN-2:0], 1'b0}
                             : {1'b0, shreg_q[FRAME_LEN-1:1]};
  assign out_bit = MSB_FIRST ? shreg_q[FRAME_LEN-1] : shreg_q[0];

  assign busy     = (state_q == SHIFT);
  assign dout     = busy & out_bit;
  assign dout_vld = busy & ser_en;
  assign sof      = busy & (cnt_q == '0);
  assign eof      = busy & (cnt_q == CNT_W'(FRAME_LEN - 1));
  // A new word can be taken while idle, or in the cycle the last bit leaves.
  assign din_rdy  = (state_q == IDLE) | (dout_vld & eof);
  assign load     = din_vld & din_rdy;

  // Next-state logic: a load takes priority over the final shift, which gives gapless frames.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = SHIFT;
      shreg_d = load_word;
      cnt_d   = '0;
    end else if (dout_vld) begin
      shreg_d = shifted;
      if (eof) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State, shift-register and counter registers. Reset aborts any frame in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_p2s_serializer.sv
// Directed testbench for p2s_serializer: an LSB-first and an MSB-first
// instance share one stimulus stream. Compile with +define+P2S_PARITY_EN to
// check the parity frame.
module tb_p2s_serializer;

`ifdef P2S_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] din;
  logic       din_vld;
  logic       ser_en;

  logic din_rdy_l, dout_l, dout_vld_l, sof_l, eof_l, busy_l;
  logic din_rdy_m, dout_m, dout_vld_m, sof_m, eof_m, busy_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  p2s_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .n_rst(n_rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy_l),
    .ser_en(ser_en), .dout(dout_l), .dout_vld(dout_vld_l), .sof(sof_l),
    .eof(eof_l), .busy(busy_l)
  );

  p2s_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .n_rst(n_rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy_m),
    .ser_en(ser_en), .dout(dout_m), .dout_vld(dout_vld_m), .sof(sof_m),
    .eof(eof_m), .busy(busy_m)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Both instances idle: nothing on the line, ready for a word.
  task automatic check_idle(input string name);
    chk({name, " busy_l"}, busy_l, 1'b0);
    chk({name, " busy_m"}, busy_m, 1'b0);
    chk({name, " dout_l"}, dout_l, 1'b0);
    chk({name, " dout_m"}, dout_m, 1'b0);
    chk({name, " dout_vld_l"}, dout_vld_l, 1'b0);
    chk({name, " sof_l"}, sof_l, 1'b0);
    chk({name, " eof_l"}, eof_l, 1'b0);
    chk({name, " din_rdy_l"}, din_rdy_l, 1'b1);
    chk({name, " din_rdy_m"}, din_rdy_m, 1'b1);
  endtask

  // Offer a word at a falling edge; it is taken at the following rising edge.
  task automatic load(input string name, input logic [7:0] d);
    din     = d;
    din_vld = 1'b1;
    ser_en  = 1'b1;
    #1;
    chk({name, " load din_rdy_l"}, din_rdy_l, 1'b1);
    chk({name, " load din_rdy_m"}, din_rdy_m, 1'b1);
    @(negedge clk);
  endtask

  // Walk one frame; exp_x[k] is the k-th bit expected on the line.
  task automatic run_frame(input string name, input logic [9:0] exp_l,
                           input logic [9:0] exp_m, input int stall_at,
                           input int stall_n, input logic [7:0] nd,
                           input logic nv);
    din     = nd;
    din_vld = nv;
    for (int k = 0; k < FL; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          ser_en = 1'b0;
          #1;
          chk($sformatf("%s stall%0d dout_l", name, s), dout_l, exp_l[k]);
          chk($sformatf("%s stall%0d dout_m", name, s), dout_m, exp_m[k]);
          chk($sformatf("%s stall%0d dout_vld_l", name, s), dout_vld_l, 1'b0);
          chk($sformatf("%s stall%0d busy_l", name, s), busy_l, 1'b1);
          chk($sformatf("%s stall%0d din_rdy_l", name, s), din_rdy_l, 1'b0);
          @(negedge clk);
        end
      end
      ser_en = 1'b1;
      #1;
      chk($sformatf("%s b%0d dout_l", name, k), dout_l, exp_l[k]);
      chk($sformatf("%s b%0d dout_m", name, k), dout_m, exp_m[k]);
      chk($sformatf("%s b%0d dout_vld_l", name, k), dout_vld_l, 1'b1);
      chk($sformatf("%s b%0d dout_vld_m", name, k), dout_vld_m, 1'b1);
      chk($sformatf("%s b%0d busy_l", name, k), busy_l, 1'b1);
      chk($sformatf("%s b%0d sof_l", name, k), sof_l, k == 0);
      chk($sformatf("%s b%0d sof_m", name, k), sof_m, k == 0);
      chk($sformatf("%s b%0d eof_l", name, k), eof_l, k == FL - 1);
      chk($sformatf("%s b%0d eof_m", name, k), eof_m, k == FL - 1);
      chk($sformatf("%s b%0d din_rdy_l", name, k), din_rdy_l, k == FL - 1);
      chk($sformatf("%s b%0d din_rdy_m", name, k), din_rdy_m, k == FL - 1);
      @(negedge clk);
    end
    $display("frame %s done: checks %0d errors %0d", name, checks, errors);
  endtask

  initial begin
    n_rst   = 1'b0;
    din     = 8'h00;
    din_vld = 1'b0;
    ser_en  = 1'b1;
    @(negedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // LSB-first 1,1,1,1,0,0,0,0 / MSB-first 0,0,0,0,1,1,1,1; parity 0.
    load("t12", 8'h0F);
    run_frame("t12", 10'b00_0000_1111, 10'b00_1111_0000, -1, 0, 8'h00, 1'b0);
    #1;
    check_idle("t12 after");
    @(negedge clk);

    // 8'hA5: third bit is 1 in both orders and must hold through 3 stall cycles.
    load("t3", 8'hA5);
    run_frame("t3", 10'b00_1010_0101, 10'b00_1010_0101, 2, 3, 8'h00, 1'b0);
    #1;
    check_idle("t3 after");
    @(negedge clk);

    // Back-to-back 8'h3C then 8'hC3 with din_vld held: no gap between frames.
    load("t4a", 8'h3C);
    run_frame("t4a", 10'b00_0011_1100, 10'b00_0011_1100, -1, 0, 8'hC3, 1'b1);
    run_frame("t4b", 10'b00_1100_0011, 10'b00_1100_0011, -1, 0, 8'h00, 1'b0);
    #1;
    check_idle("t4 after");
    @(negedge clk);

    // Reset mid-frame after 4 bits of 8'hFF, then a clean 8'h01 frame.
    load("t5", 8'hFF);
    din_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t5 pre b%0d dout_l", k), dout_l, 1'b1);
      chk($sformatf("t5 pre b%0d dout_m", k), dout_m, 1'b1);
      @(negedge clk);
    end
    n_rst = 1'b0;
    #1;
    check_idle("t5 async rst");
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    load("t5", 8'h01);
    run_frame("t5", 10'b01_0000_0001, 10'b01_1000_0000, -1, 0, 8'h00, 1'b0);
    #1;
    check_idle("t5 after");
    @(negedge clk);

    // 8'h07: 1,1,1,0,0,0,0,0 then parity 1 when enabled.
    load("t6", 8'h07);
    run_frame("t6", 10'b01_0000_0111, 10'b01_1110_0000, -1, 0, 8'h00, 1'b0);
    #1;
    check_idle("t6 after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
